// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS pipeline: stage keep/clear, PC hold/redirect,
// load-use and taken-branch handling, data-memory wait sequencing with timeout, stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_uses_rs_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rt_i,
  input  logic             mem_branch_taken_i,
  input  logic             mem_access_i,
  input  logic             dmem_ready_i,
  output logic             pc_keep_o,
  output logic             pc_src_o,
  output logic             if_id_keep_o,
  output logic             id_ex_keep_o,
  output logic             ex_mem_keep_o,
  output logic             mem_wb_keep_o,
  output logic             if_id_clear_o,
  output logic             id_ex_clear_o,
  output logic             ex_mem_clear_o,
  output logic             mem_wb_clear_o,
  output logic             dmem_req_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  logic       memwait, flush, loaduse, freeze;
  logic       pc_keep, pc_src, req, halt, do_flush;
  // Stage vectors: [0] IF/ID, [1] ID/EX, [2] EX/MEM, [3] MEM/WB
  logic [3:0] keep, clear, keep_res;

  assign memwait = mem_access_i & ~dmem_ready_i;
  assign flush   = mem_branch_taken_i;
  assign loaduse = ex_memread_i & (ex_rt_i != 5'd0) &
                   ((id_uses_rs_i & (id_rs_i == ex_rt_i)) |
                    (id_uses_rt_i & (id_rt_i == ex_rt_i)));

  // In MEM_WAIT the freeze lasts until ready, independent of mem_access_i
  assign freeze = (state == MEM_WAIT) ? ~dmem_ready_i : memwait;

  // Next state, wait counter and raw control outputs
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    pc_keep      = 1'b0;
    pc_src       = 1'b0;
    keep         = 4'b0000;
    clear        = 4'b0000;
    req          = 1'b0;
    halt         = 1'b0;
    do_flush     = 1'b0;
    case (state)
      RUN, MEM_WAIT: begin
        req = mem_access_i;
        if (freeze) begin
          pc_keep = 1'b1;
          keep    = 4'b0111;
          clear   = 4'b1000;
          if (state == RUN) begin
            state_nxt    = MEM_WAIT;
            wait_cnt_nxt = WAIT_W'(1);
          end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
            state_nxt = HALT;
          end else begin
            wait_cnt_nxt = wait_cnt + WAIT_W'(1);
          end
        end else begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
          if (flush) begin
            pc_src   = 1'b1;
            clear    = 4'b0111;
            do_flush = 1'b1;
          end else if (loaduse) begin
            pc_keep = 1'b1;
            keep    = 4'b0001;
            clear   = 4'b0010;
          end
        end
      end
      HALT: begin
        pc_keep = 1'b1;
        keep    = 4'b1111;
        clear   = 4'b1000;
        halt    = 1'b1;
      end
      default: state_nxt = RUN;
    endcase
  end

  // A register never sees keep and clear together; clear wins
  assign keep_res = keep & ~clear;

  assign pc_keep_o      = rst_i & pc_keep;
  assign pc_src_o       = rst_i & pc_src;
  assign if_id_keep_o   = rst_i & keep_res[0];
  assign id_ex_keep_o   = rst_i & keep_res[1];
  assign ex_mem_keep_o  = rst_i & keep_res[2];
  assign mem_wb_keep_o  = rst_i & keep_res[3];
  assign if_id_clear_o  = rst_i & clear[0];
  assign id_ex_clear_o  = rst_i & clear[1];
  assign ex_mem_clear_o = rst_i & clear[2];
  assign mem_wb_clear_o = rst_i & clear[3];
  assign dmem_req_o     = rst_i & req;
  assign halted_o       = rst_i & halt;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Saturating event counters, frozen in HALT
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((state != HALT) && pc_keep && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (do_flush && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed vector bench for pipeline_hazard_ctrl: a main instance with a short memory timeout
// and a second instance with 2-bit counters for saturation.
module tb_pipeline_hazard_ctrl;

  localparam logic [11:0] O_PCK  = 12'h800;
  localparam logic [11:0] O_SRC  = 12'h400;
  localparam logic [11:0] O_KIF  = 12'h200;
  localparam logic [11:0] O_KIDX = 12'h100;
  localparam logic [11:0] O_KEXM = 12'h080;
  localparam logic [11:0] O_KMWB = 12'h040;
  localparam logic [11:0] O_CIF  = 12'h020;
  localparam logic [11:0] O_CIDX = 12'h010;
  localparam logic [11:0] O_CEXM = 12'h008;
  localparam logic [11:0] O_CMWB = 12'h004;
  localparam logic [11:0] O_REQ  = 12'h002;
  localparam logic [11:0] O_HLT  = 12'h001;

  localparam logic [11:0] E_NONE = 12'h000;
  localparam logic [11:0] E_LU   = O_PCK | O_KIF | O_CIDX;
  localparam logic [11:0] E_FL   = O_SRC | O_CIF | O_CIDX | O_CEXM;
  localparam logic [11:0] E_FRZ  = O_PCK | O_KIF | O_KIDX | O_KEXM | O_CMWB | O_REQ;
  localparam logic [11:0] E_HALT = O_PCK | O_KIF | O_KIDX | O_KEXM | O_CMWB | O_HLT;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rs, id_uses_rt, ex_memread, br_taken, mem_access, dmem_ready;

  logic        pc_keep, pc_src, if_id_keep, id_ex_keep, ex_mem_keep, mem_wb_keep;
  logic        if_id_clear, id_ex_clear, ex_mem_clear, mem_wb_clear, dmem_req, halted;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_pc_keep, s_pc_src, s_if_id_keep, s_id_ex_keep, s_ex_mem_keep, s_mem_wb_keep;
  logic        s_if_id_clear, s_id_ex_clear, s_ex_mem_clear, s_mem_wb_clear, s_dmem_req, s_halted;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  logic [11:0] act;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(16), .MEM_TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rs_i(id_uses_rs), .id_uses_rt_i(id_uses_rt),
    .ex_memread_i(ex_memread), .ex_rt_i(ex_rt), .mem_branch_taken_i(br_taken),
    .mem_access_i(mem_access), .dmem_ready_i(dmem_ready),
    .pc_keep_o(pc_keep), .pc_src_o(pc_src),
    .if_id_keep_o(if_id_keep), .id_ex_keep_o(id_ex_keep),
    .ex_mem_keep_o(ex_mem_keep), .mem_wb_keep_o(mem_wb_keep),
    .if_id_clear_o(if_id_clear), .id_ex_clear_o(id_ex_clear),
    .ex_mem_clear_o(ex_mem_clear), .mem_wb_clear_o(mem_wb_clear),
    .dmem_req_o(dmem_req), .halted_o(halted),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  pipeline_hazard_ctrl #(.CNT_W(2), .MEM_TIMEOUT(64)) dut_sat (
    .clk_i(clk), .rst_i(rst),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rs_i(id_uses_rs), .id_uses_rt_i(id_uses_rt),
    .ex_memread_i(ex_memread), .ex_rt_i(ex_rt), .mem_branch_taken_i(br_taken),
    .mem_access_i(mem_access), .dmem_ready_i(dmem_ready),
    .pc_keep_o(s_pc_keep), .pc_src_o(s_pc_src),
    .if_id_keep_o(s_if_id_keep), .id_ex_keep_o(s_id_ex_keep),
    .ex_mem_keep_o(s_ex_mem_keep), .mem_wb_keep_o(s_mem_wb_keep),
    .if_id_clear_o(s_if_id_clear), .id_ex_clear_o(s_id_ex_clear),
    .ex_mem_clear_o(s_ex_mem_clear), .mem_wb_clear_o(s_mem_wb_clear),
    .dmem_req_o(s_dmem_req), .halted_o(s_halted),
    .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt)
  );

  assign act = {pc_keep, pc_src, if_id_keep, id_ex_keep, ex_mem_keep, mem_wb_keep,
                if_id_clear, id_ex_clear, ex_mem_clear, mem_wb_clear, dmem_req, halted};

  typedef struct {
    logic [4:0]  rs, rt, ex_rt;
    logic        urs, urt, memread, br, acc, rdy;
    logic [11:0] exp;
    logic [15:0] stall, flush;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt,
                              input logic urs, input logic urt, input logic memread,
                              input logic [4:0] ert, input logic br, input logic acc,
                              input logic rdy, input logic [11:0] exp,
                              input logic [15:0] stall, input logic [15:0] flush);
    vec_t v;
    v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.memread = memread; v.ex_rt = ert;
    v.br = br; v.acc = acc; v.rdy = rdy; v.exp = exp; v.stall = stall; v.flush = flush;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    id_rs = v.rs; id_rt = v.rt; id_uses_rs = v.urs; id_uses_rt = v.urt;
    ex_memread = v.memread; ex_rt = v.ex_rt; br_taken = v.br;
    mem_access = v.acc; dmem_ready = v.rdy;
  endtask

  // Drive, check outputs mid-cycle, clock, then check counters
  task automatic step(input string name, input vec_t v);
    drive(v);
    @(negedge clk);
    check({name, ".out"}, 32'(act), 32'(v.exp));
    @(posedge clk);
    #1;
    check({name, ".stall"}, 32'(stall_cnt), 32'(v.stall));
    check({name, ".flush"}, 32'(flush_cnt), 32'(v.flush));
  endtask

  vec_t tbl[17];
  vec_t v;

  initial begin
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_NONE,         0, 0);
    tbl[1]  = mk(5, 0, 1, 0, 1, 5, 0, 0, 0, E_LU,           1, 0);
    tbl[2]  = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, E_NONE,         1, 0);
    tbl[3]  = mk(0, 7, 0, 1, 1, 7, 0, 0, 0, E_LU,           2, 0);
    tbl[4]  = mk(9, 3, 0, 1, 1, 9, 0, 0, 0, E_NONE,         2, 0);
    tbl[5]  = mk(5, 0, 1, 0, 0, 5, 0, 0, 0, E_NONE,         2, 0);
    tbl[6]  = mk(5, 0, 1, 0, 1, 5, 1, 0, 0, E_FL,           2, 1);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, E_FRZ,          3, 1);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, E_FRZ,          4, 1);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, E_FRZ,          5, 1);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, O_REQ,          5, 1);
    tbl[11] = mk(5, 0, 1, 0, 1, 5, 0, 1, 1, E_LU | O_REQ,   6, 1);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, E_FRZ,          7, 1);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, E_FRZ,          8, 1);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, E_FL | O_REQ,   8, 2);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_NONE,         8, 2);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, E_NONE,         8, 2);

    // Reset with a load-use pattern present: controls must stay low
    rst = 1'b0;
    drive(tbl[1]);
    @(negedge clk);
    check("rst_out", 32'(act), 32'(E_NONE));
    @(posedge clk);
    #1;
    check("rst_stall", 32'(stall_cnt), 32'(0));
    check("rst_flush", 32'(flush_cnt), 32'(0));
    rst = 1'b1;

    for (int i = 0; i < 17; i++) step($sformatf("vec%0d", i), tbl[i]);

    // Timeout: one RUN freeze plus four MEM_WAIT cycles, then HALT
    v = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, E_FRZ, 9, 2);
    for (int i = 0; i < 5; i++) begin
      step($sformatf("tmo%0d", i), v);
      v.stall = v.stall + 16'd1;
    end
    v = mk(5, 0, 1, 0, 1, 5, 1, 1, 1, E_HALT, 13, 2);
    for (int i = 0; i < 3; i++) step($sformatf("halt%0d", i), v);

    // Reset out of HALT
    rst = 1'b0;
    @(negedge clk);
    check("halt_rst_out", 32'(act), 32'(E_NONE));
    @(posedge clk);
    #1;
    rst = 1'b1;
    step("post_halt", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_NONE, 0, 0));

    // Reset mid-MEM_WAIT: afterwards a non-ready cycle must not freeze
    step("mw_enter", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, E_FRZ, 1, 0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    step("mw_rst", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, E_NONE, 0, 0));

    // Saturation on the 2-bit instance
    v = mk(5, 0, 1, 0, 1, 5, 0, 0, 0, E_LU, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step($sformatf("sat%0d", i), v);
      check($sformatf("sat%0d.cnt2", i), 32'(s_stall_cnt), (i < 3) ? 32'(i + 1) : 32'(3));
      v.stall = v.stall + 16'd1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
